quantize_writeback: RTL and testbench
=====================================

// Module: quantize_writeback
// PURPOSE
//  Sink stage directly downstream of the quantization stage. Accepts one row of ARRAY_SIZE
//  saturated 16-bit results per valid/ready transfer and packs them into SRAM_DATA_WIDTH words.
//  Writes the words to the output SRAM one per cycle at consecutive addresses from a programmable base.
//  Signals completion when the row tagged last has been fully written.
// PARAMETERS
//  ARRAY_SIZE        32  elements per row (must be a multiple of EPW)
//  OUTPUT_DATA_WIDTH 16  width of one quantized element
//  SRAM_DATA_WIDTH   32  SRAM word width; EPW = SRAM_DATA_WIDTH/OUTPUT_DATA_WIDTH (=2), WPR = ARRAY_SIZE/EPW (=16)
//  ADDR_WIDTH        10  SRAM address width
// PORTS
//  clk            in   1                         clock, rising edge
//  rst_n          in   1                         asynchronous active-low reset
//  start          in   1                         load write pointer from cfg_base_addr (IDLE only)
//  cfg_base_addr  in   ADDR_WIDTH                first SRAM address of the output tile
//  in_valid       in   1                         row available from quantizer
//  in_ready       out  1                         row accepted when in_valid & in_ready
//  in_last        in   1                         accepted row is the final row of the tile
//  in_data        in   ARRAY_SIZE*OUTPUT_DATA_WIDTH  element i at [i*16 +: 16]
//  sram_we        out  1                         write strobe, active high
//  sram_waddr     out  ADDR_WIDTH                write address
//  sram_wdata     out  SRAM_DATA_WIDTH           packed write data
//  busy           out  1                         high in WRITE state
//  done           out  1                         one-cycle pulse with the last word of the in_last row
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, wr_ptr=0, word_cnt=0, last_q=0, row buffer=0;
//   sram_we=0, sram_waddr=0, sram_wdata=0, busy=0, done=0. All outputs except in_ready registered.
//  States: IDLE, WRITE.
//  in_ready = !start & (state==IDLE | (state==WRITE & word_cnt==WPR-1)); combinational.
//  IDLE: start=1 -> wr_ptr<=cfg_base_addr, stay IDLE; start has priority, no row accepted that cycle.
//   Accept -> capture in_data into row buffer, last_q<=in_last, word_cnt<=0, go WRITE.
//  WRITE, every cycle: sram_we<=1, sram_waddr<=wr_ptr, sram_wdata<=word[word_cnt],
//   wr_ptr<=wr_ptr+1 (mod 2^ADDR_WIDTH, wraps silently), word_cnt<=word_cnt+1. start is ignored.
//  Packing: word[k] bits [j*16 +: 16] = element k*EPW+j (element 0 in word 0 bits [15:0]).
//  Final word (word_cnt==WPR-1): done<=last_q. If a row is accepted this cycle, reload buffer,
//   word_cnt<=0, stay WRITE (zero-bubble back-to-back); else go IDLE.
//  Latency: row accepted at edge T -> word 0 visible on SRAM port after T+1, word WPR-1 after T+WPR.
//   Throughput 1 row / WPR cycles sustained.
//  IDLE: sram_we<=0, done<=0; sram_waddr/sram_wdata hold last value.
//  wr_ptr is not reset by done; consecutive tiles continue addressing unless start is issued.
//  Reset mid-row: writes stop immediately, partial row is lost, no done pulse.
//  in_data must be stable only in the accept cycle. Data after accept is not sampled.
// STRUCTURE
//  Shared header tpu_params.vh: ARRAY_SIZE, OUTPUT_DATA_WIDTH, SRAM_DATA_WIDTH, ADDR_WIDTH defaults, EPW/WPR derivation, state encodings.
//  One sub-module: qwb_word_mux (combinational, selects word[word_cnt] from the row buffer).
//  FSM, counters and output registers live in the top.
// TESTING
//  1) Reset, start with base=0x040, one row element i=i, in_last=1 -> 16 writes at 0x040..0x04F;
//     word 0=0x0001_0000, word 15=0x001F_001E; done high with the 0x04F write only.
//  2) Rows A,B offered back-to-back, in_valid held -> B accepted on A's final-word cycle;
//     32 contiguous sram_we cycles, addresses continuous, single done with B's last word (B in_last=1).
//  3) base=0x3F8, one row -> addresses 0x3F8..0x3FF then 0x000..0x007; no error, no stall.
//  4) Saturated values 0x7FFF/0x8000 alternating -> word = 0x8000_7FFF exactly (no sign extension across halves).
//  5) start pulsed in WRITE with base=0x100 -> ignored, current row completes at old addresses;
//     start and in_valid in same IDLE cycle -> no accept, pointer=base, accept next cycle.
//  6) rst_n low after 5 words written -> sram_we=0 asynchronously, done never pulses;
//     after release in_ready=1, wr_ptr=0.

Source files
------------

// File: rtl/quantize_writeback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quantize_writeback_pkg                                                   |
// | Shared defaults, FSM state type and sizing helper for the writeback slice|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package quantize_writeback_pkg;

  localparam int QWB_ARRAY_SIZE        = 32;
  localparam int QWB_OUTPUT_DATA_WIDTH = 16;
  localparam int QWB_SRAM_DATA_WIDTH   = 32;
  localparam int QWB_ADDR_WIDTH        = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } qwb_state_e;

  // Counter width for n values; never narrower than one bit.
  function automatic int qwb_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qwb_word_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qwb_word_mux                                                             |
// | Selects one packed SRAM word out of a buffered row of quantized elements.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qwb_word_mux
  import quantize_writeback_pkg::*;
#(
  parameter int ARRAY_SIZE        = QWB_ARRAY_SIZE,
  parameter int OUTPUT_DATA_WIDTH = QWB_OUTPUT_DATA_WIDTH,
  parameter int SRAM_DATA_WIDTH   = QWB_SRAM_DATA_WIDTH
) (
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]                           row,
  input  logic [qwb_cnt_width(ARRAY_SIZE/(SRAM_DATA_WIDTH/OUTPUT_DATA_WIDTH))-1:0] sel,
  output logic [SRAM_DATA_WIDTH-1:0]                                        word
);

  localparam int EPW = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int WPR = ARRAY_SIZE / EPW;

  logic [SRAM_DATA_WIDTH-1:0] w_words [WPR];

  // Element k*EPW+j lands in word k, lane j (lane 0 in the low bits).
  for (genvar k = 0; k < WPR; k++) begin : g_word
    for (genvar j = 0; j < EPW; j++) begin : g_elem
      assign w_words[k][j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
        row[(k*EPW+j)*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
    end
  end

  assign word = w_words[sel];

endmodule

`default_nettype wire

// File: rtl/quantize_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quantize_writeback                                                       |
// | Accepts quantized rows and streams them to SRAM one packed word a cycle. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module quantize_writeback
  import quantize_writeback_pkg::*;
#(
  parameter int ARRAY_SIZE        = QWB_ARRAY_SIZE,
  parameter int OUTPUT_DATA_WIDTH = QWB_OUTPUT_DATA_WIDTH,
  parameter int SRAM_DATA_WIDTH   = QWB_SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH        = QWB_ADDR_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [ADDR_WIDTH-1:0]                   cfg_base_addr,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_last,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
  output logic                                    sram_we,
  output logic [ADDR_WIDTH-1:0]                   sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0]              sram_wdata,
  output logic                                    busy,
  output logic                                    done
);

  localparam int EPW   = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int WPR   = ARRAY_SIZE / EPW;
  localparam int CNT_W = qwb_cnt_width(WPR);
  localparam logic [CNT_W-1:0] c_last_word = CNT_W'(WPR - 1);

  qwb_state_e                              r_state;
  qwb_state_e                              w_state_nxt;
  logic [ADDR_WIDTH-1:0]                   r_wr_ptr;
  logic [CNT_W-1:0]                        r_word_cnt;
  logic                                    r_last_q;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] r_row;
  logic                                    r_sram_we;
  logic [ADDR_WIDTH-1:0]                   r_sram_waddr;
  logic [SRAM_DATA_WIDTH-1:0]              r_sram_wdata;
  logic                                    r_done;
  logic [SRAM_DATA_WIDTH-1:0]              w_word;
  logic                                    w_final;
  logic                                    w_in_ready;
  logic                                    w_accept;

  // Ready on the final word too, so a waiting row follows with no bubble.
  assign w_final    = (r_state == ST_WRITE) && (r_word_cnt == c_last_word);
  assign w_in_ready = !start && ((r_state == ST_IDLE) || w_final);
  assign w_accept   = in_valid && w_in_ready;

  qwb_word_mux #(
    .ARRAY_SIZE        (ARRAY_SIZE),
    .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
    .SRAM_DATA_WIDTH   (SRAM_DATA_WIDTH)
  ) u_word_mux (
    .row  (r_row),
    .sel  (r_word_cnt),
    .word (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_final && !w_accept) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_word_cnt   <= '0;
      r_last_q     <= 1'b0;
      r_row        <= '0;
      r_sram_we    <= 1'b0;
      r_sram_waddr <= '0;
      r_sram_wdata <= '0;
      r_done       <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_sram_we <= 1'b0;
        r_done    <= 1'b0;
        if (start) r_wr_ptr <= cfg_base_addr;
      end else begin
        r_sram_we    <= 1'b1;
        r_sram_waddr <= r_wr_ptr;
        r_sram_wdata <= w_word;
        r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
        r_word_cnt   <= w_final ? '0 : r_word_cnt + CNT_W'(1);
        r_done       <= w_final && r_last_q;
      end
      if (w_accept) begin
        r_row      <= in_data;
        r_last_q   <= in_last;
        r_word_cnt <= '0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign sram_we    = r_sram_we;
  assign sram_waddr = r_sram_waddr;
  assign sram_wdata = r_sram_wdata;
  assign busy       = (r_state == ST_WRITE);
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_quantize_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_quantize_writeback                                                    |
// | Scoreboard bench: cycle-level reference model feeds expected SRAM writes.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_quantize_writeback;

  localparam int AS  = 32;
  localparam int ODW = 16;
  localparam int SDW = 32;
  localparam int AW  = 10;
  localparam int EPW = SDW / ODW;
  localparam int WPR = AS / EPW;
  localparam int RW  = AS * ODW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic          sram_we;
  logic [AW-1:0] sram_waddr;
  logic [SDW-1:0] sram_wdata;
  logic          busy;
  logic          done;

  quantize_writeback dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_data       (in_data),
    .sram_we       (sram_we),
    .sram_waddr    (sram_waddr),
    .sram_wdata    (sram_wdata),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [SDW-1:0] data;
    logic           done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ptr = 0;
  int   m_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, sampled just before each rising edge. m_pend counts the
  // words the DUT still owes; a new row may enter once at most one remains.
  initial begin
    bit             exp_ready;
    bit             acc;
    logic [SDW-1:0] words [WPR];
    exp_t           e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        sb.delete();
        m_pend = 0;
        m_ptr  = 0;
      end else begin
        exp_ready = !start && (m_pend <= 1);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(m_pend > 0));
        if (start && m_pend == 0) m_ptr = int'(cfg_base_addr);
        acc = in_valid && exp_ready;
        m_pend = (m_pend > 0) ? m_pend - 1 : 0;
        if (acc) begin
          for (int k = 0; k < WPR; k++) words[k] = '0;
          for (int el = 0; el < AS; el++)
            words[el / EPW] = words[el / EPW] |
              (SDW'(in_data[el*ODW +: ODW]) << ((el % EPW) * ODW));
          for (int k = 0; k < WPR; k++) begin
            e.addr = AW'((m_ptr + k) % (1 << AW));
            e.data = words[k];
            e.done = in_last && (k == WPR - 1);
            sb.push_back(e);
          end
          m_ptr  = (m_ptr + WPR) % (1 << AW);
          m_pend = m_pend + WPR;
        end
      end
    end
  end

  // Monitor: every write strobe must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sram_we) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", sram_waddr, sram_wdata);
        end else begin
          e = sb.pop_front();
          chk("waddr", 64'(sram_waddr), 64'(e.addr));
          chk("wdata", 64'(sram_wdata), 64'(e.data));
          chk("done",  64'(done), 64'(e.done));
        end
      end else if (done) begin
        chk("done_without_we", 64'(done), 64'(0));
      end
    end
  end

  // All stimulus tasks start and end at a falling edge.
  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1;
    cfg_base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_row(input logic [RW-1:0] row, input logic last,
                          input logic with_start, input logic [AW-1:0] base);
    bit got;
    got      = 1'b0;
    in_data  = row;
    in_last  = last;
    in_valid = 1'b1;
    if (with_start) begin
      start = 1'b1;
      cfg_base_addr = base;
    end
    for (int c = 0; c < 200 && !got; c++) begin
      #4;
      got = in_ready;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = {16{$urandom}};
    in_last  = 1'($urandom);
    if (!got) chk("accept_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      idle = (m_pend == 0) && (sb.size() == 0);
    end
    if (!idle) chk("drain_timeout", 64'(idle), 64'(1));
  endtask

  function automatic logic [RW-1:0] ramp_row();
    logic [RW-1:0] r;
    for (int i = 0; i < AS; i++) r[i*ODW +: ODW] = ODW'(i);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < AS; i++)
      case ($urandom_range(0, 3))
        0:       r[i*ODW +: ODW] = 16'h7FFF;
        1:       r[i*ODW +: ODW] = 16'h8000;
        default: r[i*ODW +: ODW] = ODW'($urandom);
      endcase
    return r;
  endfunction

  initial begin
    logic [RW-1:0] row;

    #1;
    chk("rst_sram_we",    64'(sram_we), 64'(0));
    chk("rst_sram_waddr", 64'(sram_waddr), 64'(0));
    chk("rst_sram_wdata", 64'(sram_wdata), 64'(0));
    chk("rst_busy",       64'(busy), 64'(0));
    chk("rst_done",       64'(done), 64'(0));
    chk("rst_in_ready",   64'(in_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp row at 0x040: words 0x0001_0000 .. 0x001F_001E, done on 0x04F.
    do_start(10'h040);
    send_row(ramp_row(), 1'b1, 1'b0, '0);
    wait_idle();

    // Back-to-back rows with valid held across the boundary.
    send_row(rand_row(), 1'b0, 1'b0, '0);
    send_row(rand_row(), 1'b1, 1'b0, '0);
    wait_idle();

    // Address wrap past the top of the SRAM.
    do_start(10'h3F8);
    send_row(rand_row(), 1'b1, 1'b0, '0);
    wait_idle();

    // Saturated alternating lanes must pack as 0x8000_7FFF.
    for (int i = 0; i < AS; i++) row[i*ODW +: ODW] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    send_row(row, 1'b1, 1'b0, '0);
    wait_idle();

    // start during WRITE is ignored; start with valid in IDLE delays accept.
    send_row(rand_row(), 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    do_start(10'h100);
    wait_idle();
    send_row(rand_row(), 1'b1, 1'b1, 10'h100);
    wait_idle();

    // Reset after five words: writes stop at once, pointer returns to zero.
    send_row(rand_row(), 1'b1, 1'b0, '0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrow_rst_we",   64'(sram_we), 64'(0));
    chk("midrow_rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_row(rand_row(), 1'b1, 1'b0, '0);
    wait_idle();

    // Randomized traffic: gaps, tile ends and stray start pulses.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) do_start(AW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_row(rand_row(), 1'($urandom), 1'($urandom_range(0, 4) == 0), AW'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
